occupancy_map_uart_dump: RTL

Reads the complete occupancy grid out of the occupancy RAM and transmits it as a raw byte stream over a UART TX line. It connects to the occupancy RAM's spare read port and to the board UART pin. It gives hardware the same full-map dump that simulation gets by direct memory inspection. It runs after mapping completes, triggered by a start pulse, and scans cells in address order 0 to MAP_CELLS-1.

---
 rtl/occupancy_map_uart_dump_if.sv | 8 +
 rtl/occupancy_map_uart_dump.sv | 96 +++++++++
 2 files changed

// File: rtl/occupancy_map_uart_dump_if.sv
// occupancy_map_uart_dump_if: occupancy RAM read port (master = dumper, slave = RAM); mem_addr, mem_rd_en, mem_rd_data
interface occupancy_map_uart_dump_if #(parameter int ADDR_WIDTH = 15);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd_en;
  logic [7:0]            mem_rd_data;
  modport master(output mem_addr, mem_rd_en, input mem_rd_data);
  modport slave(input mem_addr, mem_rd_en, output mem_rd_data);
endinterface

// File: rtl/occupancy_map_uart_dump.sv
// occupancy_map_uart_dump: on start, reads cells 0..MAP_CELLS-1 and sends each as an 8N1 UART byte on tx; ports clk, reset_n (async low), start, mem (RAM read port), tx, busy, done; define MAP_DUMP_CHECKSUM_EN to append an XOR checksum byte
module occupancy_map_uart_dump #(
  parameter int MAP_CELLS    = 32768,
  parameter int ADDR_WIDTH   = $clog2(MAP_CELLS),
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  occupancy_map_uart_dump_if.master mem,
  output logic                     tx,
  output logic                     busy,
  output logic                     done
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {
    IDLE, READ, LATCH, SEND, DONE
`ifdef MAP_DUMP_CHECKSUM_EN
    , CHKSUM
`endif
  } state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] idx;
  logic [9:0] shift;
  logic [BW-1:0] baud;
  logic [3:0] bitc;
  logic bit_end, byte_end, last, shifting;
  assign bit_end  = baud == BW'(CLKS_PER_BIT - 1);
  assign byte_end = bit_end && bitc == 4'd9;
  assign last     = idx == ADDR_WIDTH'(MAP_CELLS - 1);
`ifdef MAP_DUMP_CHECKSUM_EN
  logic [7:0] chk;
  logic ck_go;
  // CHKSUM spends its first cycle loading the frame, then shifts it out like SEND
  assign shifting = state == SEND || (state == CHKSUM && ck_go);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      chk   <= '0;
      ck_go <= 1'b0;
    end else begin
      chk   <= (state == IDLE && start) ? '0 : (state == LATCH) ? chk ^ mem.mem_rd_data : chk;
      ck_go <= state == CHKSUM;
    end
`else
  assign shifting = state == SEND;
`endif
  // tx is decoded from the asynchronously reset state, so reset forces the line high at once
  assign tx            = shifting ? shift[0] : 1'b1;
  assign busy          = state != IDLE && state != DONE;
  assign done          = state == DONE;
  assign mem.mem_rd_en = state == READ;
  assign mem.mem_addr  = idx;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = start ? READ : IDLE;
      READ:  state_n = LATCH;
      LATCH: state_n = SEND;
`ifdef MAP_DUMP_CHECKSUM_EN
      SEND:   state_n = !byte_end ? SEND : last ? CHKSUM : READ;
      CHKSUM: state_n = (ck_go && byte_end) ? DONE : CHKSUM;
`else
      SEND:   state_n = !byte_end ? SEND : last ? DONE : READ;
`endif
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      idx   <= '0;
      shift <= '1;
      baud  <= '0;
      bitc  <= '0;
    end else begin
      if (state == IDLE && start) idx <= '0;
      else if (state == SEND && byte_end && !last) idx <= idx + 1'b1;
      if (state == LATCH) begin
        shift <= {1'b1, mem.mem_rd_data, 1'b0};
        baud  <= '0;
        bitc  <= '0;
`ifdef MAP_DUMP_CHECKSUM_EN
      end else if (state == CHKSUM && !ck_go) begin
        shift <= {1'b1, chk, 1'b0};
        baud  <= '0;
        bitc  <= '0;
`endif
      end else if (shifting) begin
        baud  <= bit_end ? '0 : baud + 1'b1;
        bitc  <= bit_end ? bitc + 1'b1 : bitc;
        shift <= bit_end ? {1'b1, shift[9:1]} : shift;
      end
    end
endmodule
